countdown_timer_p: RTL and testbench

Parametrised countdown timer for the microwave controller: loads a minutes/seconds setpoint, counts down in RUN at one decrement per second, and supports pause/resume and stop. It also pulses `done` at expiry. The 1 Hz tick is a clock-enable from an internal prescaler; no derived clock is generated. The block drives binary remaining time plus a 16-bit BCD digit bus for the 7-segment display driver.

---
 rtl/countdown_timer_p_if.sv | 28 ++
 rtl/countdown_timer_p.sv | 162 ++++++++++++++++
 tb/tb_countdown_timer_p.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_p_if.sv
// Button, setpoint and display bundle for countdown_timer_p.
// master drives buttons/setpoint, slave is the timer itself.
interface countdown_timer_p_if;
  logic        start;
  logic        stop;
  logic        pause;
  logic [6:0]  min;
  logic [6:0]  sec;
  logic        done;
  logic        running;
  logic        paused;
  logic [6:0]  rem_min;
  logic [6:0]  rem_sec;
  logic [15:0] bcd;
  logic        alarm;

  modport master (
    output start, stop, pause, min, sec,
    input  done, running, paused,
    input  rem_min, rem_sec, bcd, alarm
  );

  modport slave (
    input  start, stop, pause, min, sec,
    output done, running, paused,
    output rem_min, rem_sec, bcd, alarm
  );
endinterface

// File: rtl/countdown_timer_p.sv
// Microwave min:sec countdown timer with 1 Hz prescaler and BCD bus.
// Optional expiry alarm enabled by defining TIMER_ALARM_EN.
module countdown_timer_p #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int MIN_MAX       = 99,
  parameter int ALARM_SECS    = 5
) (
  input logic clock,
  input logic reset,
  countdown_timer_p_if.slave s
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRE_TC = PW'(TICKS_PER_SEC - 1);
  localparam logic [6:0] MINC = 7'(MIN_MAX);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [6:0]    rmin_q, rmin_d;
  logic [6:0]    rsec_q, rsec_d;
  logic          done_q, done_d;
  logic [2:0]    hist_q;
  logic [2:0]    btn;
  logic          st_e, sp_e, pa_e;
  logic [6:0]    min_c, sec_c;
  logic          tick, expire;

  assign btn = {s.start, s.stop, s.pause};
  assign {st_e, sp_e, pa_e} = btn & ~hist_q;

  assign min_c = (s.min > MINC) ? MINC : s.min;
  assign sec_c = (s.sec > 7'd59) ? 7'd59 : s.sec;

  assign tick   = (pre_q == PRE_TC);
  assign expire = tick && (rmin_q == 7'd0)
               && (rsec_q <= 7'd1);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    rmin_d  = rmin_q;
    rsec_d  = rsec_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        rmin_d = min_c;
        rsec_d = sec_c;
        if (st_e && (min_c != 7'd0 ||
                     sec_c != 7'd0)) begin
          state_d = RUN;
          pre_d   = '0;
        end
      end
      RUN: begin
        pre_d = tick ? '0 : pre_q + PW'(1);
        if (tick) begin
          if (rsec_q != 7'd0) begin
            rsec_d = rsec_q - 7'd1;
          end else begin
            rmin_d = rmin_q - 7'd1;
            rsec_d = 7'd59;
          end
        end
        if (sp_e) begin
          state_d = IDLE;
          rmin_d  = '0;
          rsec_d  = '0;
          pre_d   = '0;
        end else if (expire) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (pa_e) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (sp_e) begin
          state_d = IDLE;
          rmin_d  = '0;
          rsec_d  = '0;
          pre_d   = '0;
        end else if (pa_e || st_e) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // history loads during reset so a held button never fires
  always_ff @(posedge clock) begin
    hist_q <= btn;
    if (!reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      rmin_q  <= '0;
      rsec_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      rmin_q  <= rmin_d;
      rsec_q  <= rsec_d;
      done_q  <= done_d;
    end
  end

  function automatic logic [7:0] to_bcd(
    input logic [6:0] v
  );
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  assign s.done    = done_q;
  assign s.running = (state_q == RUN);
  assign s.paused  = (state_q == PAUSE);
  assign s.rem_min = rmin_q;
  assign s.rem_sec = rsec_q;
  assign s.bcd     = {to_bcd(rmin_q), to_bcd(rsec_q)};

`ifdef TIMER_ALARM_EN
  localparam int ACYC = ALARM_SECS * TICKS_PER_SEC;
  localparam int AW   = $clog2(ACYC);

  logic          alarm_q, alarm_d;
  logic [AW-1:0] acnt_q, acnt_d;

  always_comb begin
    alarm_d = alarm_q;
    acnt_d  = acnt_q;
    if (done_d) begin
      alarm_d = 1'b1;
      acnt_d  = '0;
    end else if (alarm_q) begin
      if (st_e || sp_e || pa_e) begin
        alarm_d = 1'b0;
      end else if (acnt_q == AW'(ACYC - 1)) begin
        alarm_d = 1'b0;
      end else begin
        acnt_d = acnt_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      alarm_q <= 1'b0;
      acnt_q  <= '0;
    end else begin
      alarm_q <= alarm_d;
      acnt_q  <= acnt_d;
    end
  end

  assign s.alarm = alarm_q;
`else
  // constant 0; the compare only keeps ALARM_SECS referenced
  assign s.alarm = (ALARM_SECS < 0);
`endif

endmodule

// File: tb/tb_countdown_timer_p.sv
// Directed bench for countdown_timer_p at TICKS_PER_SEC=4.
// Alarm checks follow TIMER_ALARM_EN.
module tb_countdown_timer_p;
  logic clock;
  logic reset;
  int   nvec;
  int   nbad;

  countdown_timer_p_if tif();

  countdown_timer_p #(
    .TICKS_PER_SEC(4),
    .MIN_MAX(99),
    .ALARM_SECS(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .s(tif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tif.start = 0; tif.stop = 0; tif.pause = 0;
    tif.min = 7'd0; tif.sec = 7'd0;
    cyc(2);
    nvec++;
    if (tif.running !== 1'b0 || tif.paused !== 1'b0) begin
      nbad++;
      $display("FAIL reset_state got run=%b pau=%b want 0 0",
               tif.running, tif.paused);
    end
    nvec++;
    if (tif.done !== 1'b0 || tif.alarm !== 1'b0 ||
        tif.rem_min !== 7'd0 || tif.rem_sec !== 7'd0) begin
      nbad++;
      $display("FAIL reset_outs got done=%b alm=%b rem=%0d:%0d want 0 0 0:0",
               tif.done, tif.alarm, tif.rem_min, tif.rem_sec);
    end
    reset = 1'b1;
    cyc(1);
  endtask

  task automatic test_basic;
    tif.min = 7'd0; tif.sec = 7'd3;
    cyc(1);
    tif.start = 1'b1;
    cyc(1);
    tif.start = 1'b0;
    nvec++;
    if (tif.running !== 1'b1) begin
      nbad++;
      $display("FAIL basic_run got %b want 1", tif.running);
    end
    for (int k = 2; k >= 1; k--) begin
      cyc(4);
      nvec++;
      if (tif.rem_sec !== 7'(k)) begin
        nbad++;
        $display("FAIL basic_dec got %0d want %0d", tif.rem_sec, k);
      end
    end
    cyc(3);
    nvec++;
    if (tif.done !== 1'b0 || tif.running !== 1'b1) begin
      nbad++;
      $display("FAIL basic_early got done=%b run=%b want 0 1",
               tif.done, tif.running);
    end
    cyc(1);
    nvec++;
    if (tif.done !== 1'b1 || tif.running !== 1'b0 ||
        tif.rem_sec !== 7'd0 || tif.rem_min !== 7'd0) begin
      nbad++;
      $display("FAIL basic_done got done=%b run=%b rem=%0d:%0d want 1 0 0:0",
               tif.done, tif.running, tif.rem_min, tif.rem_sec);
    end
    cyc(1);
    nvec++;
    if (tif.done !== 1'b0 || tif.rem_sec !== 7'd3) begin
      nbad++;
      $display("FAIL basic_after got done=%b sec=%0d want 0 3",
               tif.done, tif.rem_sec);
    end
  endtask

  task automatic test_borrow;
    tif.min = 7'd1; tif.sec = 7'd0;
    cyc(1);
    tif.start = 1'b1;
    cyc(1);
    tif.start = 1'b0;
    cyc(4);
    nvec++;
    if (tif.rem_min !== 7'd0 || tif.rem_sec !== 7'd59 ||
        tif.bcd !== 16'h0059) begin
      nbad++;
      $display("FAIL borrow got %0d:%0d bcd=%h want 0:59 0059",
               tif.rem_min, tif.rem_sec, tif.bcd);
    end
    tif.stop = 1'b1;
    cyc(1);
    tif.stop = 1'b0;
    nvec++;
    if (tif.running !== 1'b0 || tif.done !== 1'b0 ||
        tif.rem_min !== 7'd0 || tif.rem_sec !== 7'd0) begin
      nbad++;
      $display("FAIL stop got run=%b done=%b rem=%0d:%0d want 0 0 0:0",
               tif.running, tif.done, tif.rem_min, tif.rem_sec);
    end
    cyc(1);
  endtask

  task automatic test_clamp;
    tif.min = 7'd120; tif.sec = 7'd75;
    cyc(1);
    nvec++;
    if (tif.rem_min !== 7'd99 || tif.rem_sec !== 7'd59 ||
        tif.bcd !== 16'h9959) begin
      nbad++;
      $display("FAIL clamp got %0d:%0d bcd=%h want 99:59 9959",
               tif.rem_min, tif.rem_sec, tif.bcd);
    end
    tif.min = 7'd0; tif.sec = 7'd0;
    cyc(1);
    tif.start = 1'b1;
    cyc(1);
    tif.start = 1'b0;
    nvec++;
    if (tif.running !== 1'b0) begin
      nbad++;
      $display("FAIL zero_start got run=%b want 0", tif.running);
    end
    cyc(5);
    nvec++;
    if (tif.running !== 1'b0 || tif.done !== 1'b0) begin
      nbad++;
      $display("FAIL zero_idle got run=%b done=%b want 0 0",
               tif.running, tif.done);
    end
  endtask

  task automatic test_pause;
    tif.min = 7'd0; tif.sec = 7'd2;
    cyc(1);
    tif.start = 1'b1;
    cyc(1);
    tif.start = 1'b0;
    cyc(1);
    tif.pause = 1'b1;
    cyc(1);
    tif.pause = 1'b0;
    nvec++;
    if (tif.paused !== 1'b1 || tif.running !== 1'b0) begin
      nbad++;
      $display("FAIL pause_enter got pau=%b run=%b want 1 0",
               tif.paused, tif.running);
    end
    cyc(10);
    nvec++;
    if (tif.rem_sec !== 7'd2 || tif.paused !== 1'b1) begin
      nbad++;
      $display("FAIL pause_hold got sec=%0d pau=%b want 2 1",
               tif.rem_sec, tif.paused);
    end
    tif.start = 1'b1;
    cyc(1);
    tif.start = 1'b0;
    nvec++;
    if (tif.running !== 1'b1) begin
      nbad++;
      $display("FAIL resume got run=%b want 1", tif.running);
    end
    cyc(1);
    nvec++;
    if (tif.rem_sec !== 7'd2) begin
      nbad++;
      $display("FAIL resume_early got sec=%0d want 2", tif.rem_sec);
    end
    cyc(1);
    nvec++;
    if (tif.rem_sec !== 7'd1) begin
      nbad++;
      $display("FAIL resume_dec got sec=%0d want 1", tif.rem_sec);
    end
    cyc(3);
    nvec++;
    if (tif.done !== 1'b0) begin
      nbad++;
      $display("FAIL pause_early got done=%b want 0", tif.done);
    end
    cyc(1);
    nvec++;
    if (tif.done !== 1'b1 || tif.running !== 1'b0) begin
      nbad++;
      $display("FAIL pause_done got done=%b run=%b want 1 0",
               tif.done, tif.running);
    end
    cyc(1);
  endtask

  task automatic test_priority;
    tif.min = 7'd0; tif.sec = 7'd3;
    cyc(1);
    tif.start = 1'b1;
    cyc(1);
    tif.start = 1'b0;
    cyc(2);
    tif.stop = 1'b1; tif.pause = 1'b1;
    cyc(1);
    tif.stop = 1'b0; tif.pause = 1'b0;
    nvec++;
    if (tif.running !== 1'b0 || tif.paused !== 1'b0 ||
        tif.done !== 1'b0 || tif.rem_sec !== 7'd0) begin
      nbad++;
      $display("FAIL stop_pause got run=%b pau=%b done=%b sec=%0d want 0 0 0 0",
               tif.running, tif.paused, tif.done, tif.rem_sec);
    end
    tif.sec = 7'd1;
    cyc(2);
    tif.start = 1'b1;
    cyc(1);
    tif.start = 1'b0;
    cyc(3);
    tif.pause = 1'b1;
    cyc(1);
    tif.pause = 1'b0;
    nvec++;
    if (tif.done !== 1'b1 || tif.running !== 1'b0 ||
        tif.paused !== 1'b0 || tif.rem_sec !== 7'd0) begin
      nbad++;
      $display("FAIL expire_pause got done=%b run=%b pau=%b sec=%0d want 1 0 0 0",
               tif.done, tif.running, tif.paused, tif.rem_sec);
    end
    cyc(1);
  endtask

  task automatic test_reset_mid;
    tif.min = 7'd0; tif.sec = 7'd5;
    cyc(1);
    tif.start = 1'b1;
    cyc(1);
    tif.start = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    nvec++;
    if (tif.running !== 1'b0 || tif.rem_sec !== 7'd0 ||
        tif.done !== 1'b0) begin
      nbad++;
      $display("FAIL reset_mid got run=%b sec=%0d done=%b want 0 0 0",
               tif.running, tif.rem_sec, tif.done);
    end
    tif.start = 1'b1;
    cyc(1);
    reset = 1'b1;
    cyc(2);
    nvec++;
    if (tif.running !== 1'b0) begin
      nbad++;
      $display("FAIL held_start got run=%b want 0", tif.running);
    end
    tif.start = 1'b0;
    cyc(1);
  endtask

  task automatic test_alarm;
    tif.min = 7'd0; tif.sec = 7'd1;
    cyc(1);
    tif.start = 1'b1;
    cyc(1);
    tif.start = 1'b0;
    cyc(4);
`ifdef TIMER_ALARM_EN
    nvec++;
    if (tif.done !== 1'b1 || tif.alarm !== 1'b1) begin
      nbad++;
      $display("FAIL alarm_rise got done=%b alm=%b want 1 1",
               tif.done, tif.alarm);
    end
    cyc(7);
    nvec++;
    if (tif.alarm !== 1'b1) begin
      nbad++;
      $display("FAIL alarm_hold got %b want 1", tif.alarm);
    end
    cyc(1);
    nvec++;
    if (tif.alarm !== 1'b0) begin
      nbad++;
      $display("FAIL alarm_end got %b want 0", tif.alarm);
    end
    tif.start = 1'b1;
    cyc(1);
    tif.start = 1'b0;
    cyc(4);
    cyc(2);
    tif.stop = 1'b1;
    cyc(1);
    tif.stop = 1'b0;
    nvec++;
    if (tif.alarm !== 1'b0) begin
      nbad++;
      $display("FAIL alarm_stop got %b want 0", tif.alarm);
    end
`else
    nvec++;
    if (tif.done !== 1'b1 || tif.alarm !== 1'b0) begin
      nbad++;
      $display("FAIL alarm_off got done=%b alm=%b want 1 0",
               tif.done, tif.alarm);
    end
`endif
    cyc(1);
    tif.start = 1'b1;
    cyc(1);
    tif.start = 1'b0;
    cyc(2);
    tif.stop = 1'b1;
    cyc(1);
    tif.stop = 1'b0;
    cyc(1);
    nvec++;
    if (tif.alarm !== 1'b0 || tif.done !== 1'b0) begin
      nbad++;
      $display("FAIL stop_no_alarm got alm=%b done=%b want 0 0",
               tif.alarm, tif.done);
    end
  endtask

  initial begin
    nvec = 0;
    nbad = 0;
    test_reset;
    test_basic;
    test_borrow;
    test_clamp;
    test_pause;
    test_priority;
    test_reset_mid;
    test_alarm;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
